// File: rtl/player_hit_ctrl.sv
// player_hit_ctrl: bullet/ship overlap detection and player damage FSM.
// Ports: clk, reset (async, active-high), restart_n (sync soft restart),
//   frame_tick, bullet pos (posX/Y_municao), ship pos (posX/Y_jogador);
//   out: lives, hit_pulse, invulneravel, player_visible, game_over.
module player_hit_ctrl #(
  parameter int PLAYER_W      = 40,
  parameter int PLAYER_H      = 20,
  parameter int BULLET_W      = 1,
  parameter int BULLET_H      = 20,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart_n,
  input  logic        frame_tick,
  input  logic [10:0] posX_municao,
  input  logic [10:0] posY_municao,
  input  logic [10:0] posX_jogador,
  input  logic [10:0] posY_jogador,
  output logic [3:0]  lives,
  output logic        hit_pulse,
  output logic        invulneravel,
  output logic        player_visible,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [11:0] PW  = 12'(PLAYER_W);
  localparam logic [11:0] PH  = 12'(PLAYER_H);
  localparam logic [11:0] BW  = 12'(BULLET_W);
  localparam logic [11:0] BH  = 12'(BULLET_H);
  localparam logic [3:0]  LIN = 4'(LIVES_INIT);
  localparam logic [7:0]  IFR = 8'(INVULN_FRAMES);

  state_t      state;
  state_t      state_n;
  logic [3:0]  lives_n;
  logic [7:0]  frame_cnt;
  logic [7:0]  frame_cnt_n;
  logic [7:0]  cnt_inc;
  logic        hit_n;
  logic        ov;
  logic        ov_q;
  logic        inv_n;
  logic        go_n;
  logic        vis_n;

  // One extra bit keeps the edge sums from wrapping.
  logic [11:0] bx;
  logic [11:0] by;
  logic [11:0] px;
  logic [11:0] py;

  assign bx = {1'b0, posX_municao};
  assign by = {1'b0, posY_municao};
  assign px = {1'b0, posX_jogador};
  assign py = {1'b0, posY_jogador};

  // posY of zero marks an empty bullet slot.
  assign ov = (posY_municao != 11'd0)
            && (bx < px + PW)
            && (px < bx + BW)
            && (by < py + PH)
            && (py < by + BH);

  assign cnt_inc = frame_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ALIVE;
      lives          <= LIN;
      frame_cnt      <= 8'd0;
      ov_q           <= 1'b0;
      hit_pulse      <= 1'b0;
      invulneravel   <= 1'b0;
      game_over      <= 1'b0;
      player_visible <= 1'b1;
    end else begin
      state          <= state_n;
      lives          <= lives_n;
      frame_cnt      <= frame_cnt_n;
      ov_q           <= restart_n & ov;
      hit_pulse      <= hit_n;
      invulneravel   <= inv_n;
      game_over      <= go_n;
      player_visible <= vis_n;
    end
  end

  // Restart wins over a hit on the same edge.
  always_comb begin
    state_n     = state;
    lives_n     = lives;
    frame_cnt_n = frame_cnt;
    hit_n       = 1'b0;
    if (!restart_n) begin
      state_n     = ALIVE;
      lives_n     = LIN;
      frame_cnt_n = 8'd0;
    end else begin
      case (state)
        ALIVE: begin
          if (ov_q) begin
            hit_n = 1'b1;
            if (lives > 4'd1) begin
              lives_n     = lives - 4'd1;
              frame_cnt_n = 8'd0;
              state_n     = INVULN;
            end else begin
              lives_n = 4'd0;
              state_n = GAME_OVER;
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            frame_cnt_n = cnt_inc;
            if (cnt_inc == IFR) begin
              state_n = ALIVE;
            end
          end
        end
        GAME_OVER: begin
          state_n = GAME_OVER;
        end
        default: begin
          state_n = ALIVE;
        end
      endcase
    end
  end

  // Decoded from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    inv_n = 1'b0;
    go_n  = 1'b0;
    vis_n = 1'b1;
    unique case (1'b1)
      (state_n == INVULN): begin
        inv_n = 1'b1;
        vis_n = ~frame_cnt_n[3];
      end
      (state_n == GAME_OVER): begin
        go_n  = 1'b1;
        vis_n = 1'b0;
      end
      default: begin
        vis_n = 1'b1;
      end
    endcase
  end

endmodule
